// File: rtl/multicycle_control_pkg.sv
// Shared core constants: opcode map (Instruction[6:2]), FSM state encoding,
// PCSel/WBSel/ALUOp encodings, and the packed control-strobe bundle.
// Used by the multicycle controller, the immediate generator and the datapath muxes.
package multicycle_control_pkg;

  // Instruction[6:2] values understood by the core.
  localparam logic [4:0] OPC_LOAD   = 5'd0;
  localparam logic [4:0] OPC_FENCE  = 5'd3;
  localparam logic [4:0] OPC_OP_IMM = 5'd4;
  localparam logic [4:0] OPC_AUIPC  = 5'd5;
  localparam logic [4:0] OPC_STORE  = 5'd8;
  localparam logic [4:0] OPC_OP     = 5'd12;
  localparam logic [4:0] OPC_LUI    = 5'd13;
  localparam logic [4:0] OPC_BRANCH = 5'd24;
  localparam logic [4:0] OPC_JALR   = 5'd25;
  localparam logic [4:0] OPC_JAL    = 5'd27;
  localparam logic [4:0] OPC_SYSTEM = 5'd28;

  // Controller states.
  typedef enum logic [2:0] {
    ST_FETCH  = 3'd0,
    ST_DECODE = 3'd1,
    ST_EXEC   = 3'd2,
    ST_MEM    = 3'd3,
    ST_WB     = 3'd4,
    ST_TRAP   = 3'd5
  } state_e;

  // Next-PC source select.
  localparam logic [1:0] PCSEL_PLUS4 = 2'd0;  // PC + 4
  localparam logic [1:0] PCSEL_IMM   = 2'd1;  // PC + Imm (branch / JAL)
  localparam logic [1:0] PCSEL_ALU   = 2'd2;  // ALU result, bit0 cleared (JALR)

  // Register write-back source select.
  localparam logic [1:0] WBSEL_ALU   = 2'd0;
  localparam logic [1:0] WBSEL_LOAD  = 2'd1;
  localparam logic [1:0] WBSEL_PC4   = 2'd2;
  localparam logic [1:0] WBSEL_IMM   = 2'd3;

  // ALU operation class.
  localparam logic [1:0] ALUOP_ADD   = 2'd0;
  localparam logic [1:0] ALUOP_CMP   = 2'd1;
  localparam logic [1:0] ALUOP_FUNCT = 2'd2;

  // ALU operand selects.
  localparam logic ALUA_RS1 = 1'b0;
  localparam logic ALUA_PC  = 1'b1;
  localparam logic ALUB_RS2 = 1'b0;
  localparam logic ALUB_IMM = 1'b1;

  // All datapath/memory control strobes in one bundle.
  typedef struct packed {
    logic       imem_req;
    logic       dmem_req;
    logic       dmem_we;
    logic       ir_write;
    logic       pc_write;
    logic [1:0] pc_sel;
    logic       reg_write;
    logic [1:0] wb_sel;
    logic       alu_src_a;
    logic       alu_src_b;
    logic [1:0] alu_op;
  } ctrl_t;

  localparam ctrl_t CTRL_IDLE = '0;

  // Opcodes that the controller executes; everything else (SYSTEM included) traps.
  function automatic logic opc_supported(input logic [4:0] opc);
    logic ok;
    case (opc)
      OPC_LOAD, OPC_FENCE, OPC_OP_IMM, OPC_AUIPC, OPC_STORE,
      OPC_OP, OPC_LUI, OPC_BRANCH, OPC_JALR, OPC_JAL: ok = 1'b1;
      default:                                        ok = 1'b0;
    endcase
    return ok;
  endfunction

  // Where an instruction goes after EXEC.
  function automatic state_e exec_next(input logic [4:0] opc);
    state_e nxt;
    case (opc)
      OPC_LOAD, OPC_STORE:   nxt = ST_MEM;
      OPC_BRANCH, OPC_FENCE: nxt = ST_FETCH;
      default:               nxt = ST_WB;
    endcase
    return nxt;
  endfunction

  // Write-back data source for instructions that finish in WB.
  function automatic logic [1:0] wb_sel_for(input logic [4:0] opc);
    logic [1:0] sel;
    case (opc)
      OPC_LOAD:          sel = WBSEL_LOAD;
      OPC_JAL, OPC_JALR: sel = WBSEL_PC4;
      OPC_LUI:           sel = WBSEL_IMM;
      default:           sel = WBSEL_ALU;
    endcase
    return sel;
  endfunction

  // Next-PC source for instructions that finish in WB.
  function automatic logic [1:0] wb_pc_sel_for(input logic [4:0] opc);
    logic [1:0] sel;
    case (opc)
      OPC_JAL:  sel = PCSEL_IMM;
      OPC_JALR: sel = PCSEL_ALU;
      default:  sel = PCSEL_PLUS4;
    endcase
    return sel;
  endfunction

endpackage

// File: rtl/multicycle_control.sv
// Multicycle RV32 controller: FETCH/DECODE/EXEC/MEM/WB FSM with sticky TRAP and retire counter.
// Latency (zero-wait): BRANCH/FENCE 3 cycles; OP/OP-IMM/LUI/AUIPC/JAL/JALR/STORE 4; LOAD 5.
// Backpressure: FETCH holds IMemReq until IMemReady, MEM holds DMemReq until DMemReady.
// Ports: clk/rst (sync, active-high); Opcode = IR[6:2] (live, stable after FETCH);
//        BranchTaken, IMemReady, DMemReady in; memory requests, datapath strobes/selects,
//        sticky Trap and 32-bit RetireCount out.
module multicycle_control
  import multicycle_control_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic [4:0]  Opcode,
  input  logic        BranchTaken,
  input  logic        IMemReady,
  input  logic        DMemReady,
  output logic        IMemReq,
  output logic        DMemReq,
  output logic        DMemWe,
  output logic        IRWrite,
  output logic        PCWrite,
  output logic [1:0]  PCSel,
  output logic        RegWrite,
  output logic [1:0]  WBSel,
  output logic        ALUSrcA,
  output logic        ALUSrcB,
  output logic [1:0]  ALUOp,
  output logic        Trap,
  output logic [31:0] RetireCount
);

  state_e      state_q, state_d;
  logic [31:0] cnt_q, cnt_d;
  ctrl_t       ctrl;
  logic        trap;

  // State register and retire counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_FETCH;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_FETCH:  if (IMemReady) state_d = ST_DECODE;
      ST_DECODE: state_d = opc_supported(Opcode) ? ST_EXEC : ST_TRAP;
      ST_EXEC:   state_d = exec_next(Opcode);
      ST_MEM: begin
        if (DMemReady) state_d = (Opcode == OPC_STORE) ? ST_FETCH : ST_WB;
      end
      ST_WB:     state_d = ST_FETCH;
      ST_TRAP:   state_d = ST_TRAP;
      default:   state_d = ST_FETCH;
    endcase
  end

  // Output decode.
  always_comb begin
    ctrl = CTRL_IDLE;
    trap = 1'b0;
    case (state_q)
      ST_FETCH: begin
        ctrl.imem_req = 1'b1;
        ctrl.ir_write = IMemReady;
      end

      ST_EXEC: begin
        case (Opcode)
          OPC_LOAD, OPC_STORE, OPC_JALR: begin
            ctrl.alu_src_a = ALUA_RS1;
            ctrl.alu_src_b = ALUB_IMM;
            ctrl.alu_op    = ALUOP_ADD;
          end
          OPC_AUIPC: begin
            ctrl.alu_src_a = ALUA_PC;
            ctrl.alu_src_b = ALUB_IMM;
            ctrl.alu_op    = ALUOP_ADD;
          end
          OPC_OP_IMM: begin
            ctrl.alu_src_a = ALUA_RS1;
            ctrl.alu_src_b = ALUB_IMM;
            ctrl.alu_op    = ALUOP_FUNCT;
          end
          OPC_OP: begin
            ctrl.alu_src_a = ALUA_RS1;
            ctrl.alu_src_b = ALUB_RS2;
            ctrl.alu_op    = ALUOP_FUNCT;
          end
          OPC_BRANCH: begin
            // Branch retires here: the compare result picks the next PC.
            ctrl.alu_src_a = ALUA_RS1;
            ctrl.alu_src_b = ALUB_RS2;
            ctrl.alu_op    = ALUOP_CMP;
            ctrl.pc_write  = 1'b1;
            ctrl.pc_sel    = BranchTaken ? PCSEL_IMM : PCSEL_PLUS4;
          end
          OPC_FENCE: begin
            ctrl.pc_write = 1'b1;
            ctrl.pc_sel   = PCSEL_PLUS4;
          end
          default: ;
        endcase
      end

      ST_MEM: begin
        ctrl.dmem_req = 1'b1;
        ctrl.dmem_we  = (Opcode == OPC_STORE);
        // A store retires on its memory completion; a load continues to WB.
        if (DMemReady && (Opcode == OPC_STORE)) begin
          ctrl.pc_write = 1'b1;
          ctrl.pc_sel   = PCSEL_PLUS4;
        end
      end

      ST_WB: begin
        ctrl.reg_write = 1'b1;
        ctrl.pc_write  = 1'b1;
        ctrl.wb_sel    = wb_sel_for(Opcode);
        ctrl.pc_sel    = wb_pc_sel_for(Opcode);
      end

      ST_TRAP: trap = 1'b1;

      default: ;
    endcase

    // While reset is asserted no access is issued and nothing retires, so an
    // in-flight fetch or memory access is abandoned cleanly. Trap keeps
    // reflecting the state until the reset edge clears it.
    if (rst) ctrl = CTRL_IDLE;
  end

  // Count one retirement per PCWrite pulse; wraps naturally at 2^32.
  always_comb begin
    cnt_d = cnt_q;
    if (ctrl.pc_write) cnt_d = cnt_q + 32'd1;
  end

  assign IMemReq     = ctrl.imem_req;
  assign DMemReq     = ctrl.dmem_req;
  assign DMemWe      = ctrl.dmem_we;
  assign IRWrite     = ctrl.ir_write;
  assign PCWrite     = ctrl.pc_write;
  assign PCSel       = ctrl.pc_sel;
  assign RegWrite    = ctrl.reg_write;
  assign WBSel       = ctrl.wb_sel;
  assign ALUSrcA     = ctrl.alu_src_a;
  assign ALUSrcB     = ctrl.alu_src_b;
  assign ALUOp       = ctrl.alu_op;
  assign Trap        = trap;
  assign RetireCount = cnt_q;

endmodule

// File: doc/multicycle_control.md
MULTICYCLE_CONTROL -- requirements
Module: multicycle_control

Interface
REQ-001 SHALL have one clock and a synchronous, active-high reset: clk and rst.
REQ-002 Ports, in this order (name  direction  width  meaning):
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  synchronous active-high reset.
- Opcode  in  5  Instruction[6:2] from the instruction register.
- BranchTaken  in  1  ALU compare result, valid in EXEC.
- IMemReady  in  1  instruction-memory data valid this cycle.
- DMemReady  in  1  data-memory access complete this cycle.
- IMemReq  out  1  instruction-fetch request.
- DMemReq  out  1  data-memory request.
- DMemWe  out  1  data-memory write enable (store).
- IRWrite  out  1  latch the fetched instruction.
- PCWrite  out  1  update PC.
- PCSel  out  2  0 PC+4, 1 PC+Imm (branch/JAL), 2 ALU result with bit0 cleared (JALR).
- RegWrite  out  1  register-file write.
- WBSel  out  2  0 ALU, 1 load data, 2 PC+4, 3 Immediate.
- ALUSrcA  out  1  0 rs1, 1 PC.
- ALUSrcB  out  1  0 rs2, 1 Immediate.
- ALUOp  out  2  0 add, 1 compare (branch), 2 funct-decoded (OP/OP-IMM).
- Trap  out  1  sticky; unsupported opcode or SYSTEM.
- RetireCount  out  32  instructions retired since reset.

Function
REQ-003 States SHALL be FETCH, DECODE, EXEC, MEM, WB, TRAP.
REQ-004 FETCH SHALL hold IMemReq=1 until IMemReady; IRWrite=IMemReady; next DECODE on IMemReady, else stay.
REQ-005 DECODE SHALL last one cycle; supported Opcode -> EXEC; any other Opcode -> TRAP.
REQ-006 Supported opcodes: 0 LOAD, 3 FENCE, 4 OP-IMM, 5 AUIPC, 8 STORE, 12 OP, 13 LUI, 24 BRANCH, 25 JALR, 27 JAL; 28 SYSTEM -> TRAP.
REQ-007 EXEC controls: LOAD/STORE/JALR add rs1+Imm; AUIPC adds PC+Imm; OP-IMM rs1,Imm,ALUOp=2; OP rs1,rs2,ALUOp=2; BRANCH rs1,rs2,ALUOp=1.
REQ-008 EXEC next state: LOAD/STORE -> MEM; BRANCH and FENCE -> FETCH; all others -> WB.
REQ-009 BRANCH in EXEC SHALL assert PCWrite with PCSel=1 if BranchTaken else 0; FENCE SHALL assert PCWrite, PCSel=0.
REQ-010 MEM SHALL hold DMemReq=1 (DMemWe=1 for STORE) until DMemReady; stay while low.
REQ-011 STORE with DMemReady -> FETCH with PCWrite, PCSel=0; LOAD with DMemReady -> WB.
REQ-012 WB SHALL assert RegWrite and PCWrite for one cycle, then FETCH; WBSel: LOAD 1, JAL/JALR 2, LUI 3, else 0; PCSel: JAL 1, JALR 2, else 0.
REQ-013 PCWrite SHALL pulse exactly once per retired instruction, in its final state; RetireCount SHALL increment on that same edge, wrapping 0xFFFFFFFF -> 0.
REQ-014 Zero-wait latencies: BRANCH/FENCE 3 cycles; OP/OP-IMM/LUI/AUIPC/JAL/JALR/STORE 4; LOAD 5.
REQ-015 TRAP SHALL be absorbing: Trap=1, all strobes and requests 0, until rst.
REQ-016 Outside their stated states, all 1-bit strobes SHALL be 0 and selects 0.

Reset
REQ-017 rst SHALL, on the next edge, force FETCH, Trap=0, RetireCount=0, from any state.
REQ-018 rst during FETCH or MEM SHALL abort the access: IMemReq/DMemReq/DMemWe low the cycle after; no PCWrite, RegWrite or count increment.
REQ-019 The first cycle after rst deasserts SHALL assert IMemReq.

Structure
REQ-020 Opcode values, state encoding and PCSel/WBSel/ALUOp encodings SHALL live in the shared core constants package, shared with the immediate generator and datapath muxes.
REQ-021 No sub-module; one registered FSM plus combinational output decode; the opcode is taken live from the IR (stable after FETCH).

Verification
REQ-022 ADDI (Opcode 4), zero-wait memories -> IMemReq, DECODE, EXEC, WB; RegWrite+PCWrite in cycle 4, RetireCount 0->1.
REQ-023 LOAD, DMemReady low 3 cycles -> MEM for 4 cycles, DMemReq high throughout, DMemWe=0, WB WBSel=1, total 8 cycles.
REQ-024 BRANCH with BranchTaken=1 then =0 -> PCSel=1 then 0, PCWrite in cycle 3, RegWrite never.
REQ-025 JALR -> WB with WBSel=2, PCSel=2, RegWrite=1, PCWrite=1.
REQ-026 Opcode 28, then 31 after reset -> Trap=1 from cycle 3, all strobes 0, RetireCount frozen; rst clears Trap and count.
REQ-027 rst mid-MEM of STORE, then 2^32 retirements preloaded by force -> requests drop next cycle, no PCWrite; RetireCount wraps to 0.
